// File: rtl/rj_pkg.sv
// rj_pkg: shared state type and elaboration helpers for the RJ TX lane serializer
package rj_pkg;
    typedef enum logic [1:0] {RJ_IDLE, RJ_LOW, RJ_HIGH} rj_tx_state_e;

    localparam int RJ_CLK_LANE_OFS = 0;

    function automatic int rj_clk_lane(input int num_lanes);
        return num_lanes + RJ_CLK_LANE_OFS;
    endfunction

    function automatic bit rj_lanes_ok(input int num_lanes, input int data_w);
        return num_lanes > 0 && data_w >= num_lanes && data_w % num_lanes == 0;
    endfunction
endpackage

// File: rtl/rj_tx_phase_gen.sv
// rj_tx_phase_gen: forwarded-clock LOW/HIGH phase FSM with per-word latched phase lengths
module rj_tx_phase_gen
    import rj_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_clk_h_i,
    input  logic [CNT_W-1:0] cfg_clk_l_i,
    input  logic             free_run_i,
    input  logic             start_i,
    input  logic             active_i,
    input  logic             more_i,
    output logic             idle_o,
    output logic             hi_end_o,
    output logic             clk_lane_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    rj_tx_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_l_q, len_l_d, len_h_q, len_h_d;
    logic             clk_q, lo_end, latch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RJ_IDLE;
            cnt_q   <= '0;
            len_l_q <= ONE;
            len_h_q <= ONE;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_l_q <= len_l_d;
            len_h_q <= len_h_d;
            clk_q   <= state_d == RJ_HIGH;
        end
    end

    // Lengths are re-latched only when a new word or a new idle period begins
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            RJ_IDLE: begin
                state_d = (start_i || free_run_i) ? RJ_LOW : RJ_IDLE;
                latch   = start_i || free_run_i;
            end
            RJ_LOW: state_d = lo_end ? ((active_i || free_run_i) ? RJ_HIGH : RJ_IDLE) : RJ_LOW;
            RJ_HIGH: begin
                state_d = hi_end_o ? ((more_i || start_i || free_run_i) ? RJ_LOW : RJ_IDLE) : RJ_HIGH;
                latch   = hi_end_o && !more_i && (start_i || free_run_i);
            end
            default: state_d = RJ_IDLE;
        endcase
        cnt_d   = (state_d != state_q || state_q == RJ_IDLE) ? '0 : cnt_q + ONE;
        len_l_d = !latch ? len_l_q : (cfg_clk_l_i == '0) ? ONE : cfg_clk_l_i;
        len_h_d = !latch ? len_h_q : (cfg_clk_h_i == '0) ? ONE : cfg_clk_h_i;
    end

    always_comb begin
        lo_end     = state_q == RJ_LOW && cnt_q == len_l_q - ONE;
        hi_end_o   = state_q == RJ_HIGH && cnt_q == len_h_q - ONE;
        idle_o     = state_q == RJ_IDLE;
        clk_lane_o = clk_q;
    end
endmodule

// File: rtl/rj_tx_lane_serializer.sv
// rj_tx_lane_serializer: shifts valid/ready words out over NUM_LANES data lanes plus a forwarded clock lane
module rj_tx_lane_serializer
    import rj_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     cfg_clk_h,
    input  logic [CNT_W-1:0]     cfg_clk_l,
    input  logic                 cfg_free_run,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [NUM_LANES:0]   rj_lane,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int            BEATS   = DATA_W / NUM_LANES;
    localparam int            BW      = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST    = BW'(BEATS - 1);
    localparam logic [BW-1:0] BONE    = BW'(1);
    localparam int            CLK_IDX = rj_clk_lane(NUM_LANES);

    if (!rj_lanes_ok(NUM_LANES, DATA_W)) begin : g_bad_cfg
        $error("DATA_W must be a non-zero multiple of NUM_LANES");
    end

    logic [DATA_W-1:0]    sh_q, sh_d;
    logic [NUM_LANES-1:0] dat_q, dat_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 busy_q, busy_d, done_q, armed_q;
    logic                 idle, hi_end, clk_lane, accept, last, step, word_end;

    rj_tx_phase_gen #(.CNT_W(CNT_W)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .cfg_clk_h_i(cfg_clk_h),
        .cfg_clk_l_i(cfg_clk_l),
        .free_run_i (cfg_free_run),
        .start_i    (accept),
        .active_i   (busy_q),
        .more_i     (busy_q && !last),
        .idle_o     (idle),
        .hi_end_o   (hi_end),
        .clk_lane_o (clk_lane)
    );

    assign last     = beat_q == LAST;
    assign step     = hi_end && busy_q && !last;
    assign word_end = hi_end && busy_q && last;
    // Free-run only hands over at a HIGH boundary so words stay phase-aligned with the idle clock
    assign in_ready = armed_q && (cfg_free_run ? hi_end && (!busy_q || last) : idle || word_end);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sh_d   = accept ? in_data >> NUM_LANES : step ? sh_q >> NUM_LANES : sh_q;
        dat_d  = accept ? in_data[NUM_LANES-1:0] : word_end ? '0 : step ? sh_q[NUM_LANES-1:0] : dat_q;
        beat_d = accept ? '0 : step ? beat_q + BONE : beat_q;
        busy_d = accept || (busy_q && !word_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            dat_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            dat_q   <= dat_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= word_end;
            armed_q <= 1'b1;
        end
    end

    assign rj_lane[CLK_IDX]       = clk_lane;
    assign rj_lane[NUM_LANES-1:0] = dat_q;
    assign busy                   = busy_q;
    assign tx_done                = done_q;
endmodule

// File: tb/tb_rj_tx_lane_serializer.sv
// tb_rj_tx_lane_serializer: directed vectors on a 1-lane/8-bit and a 4-lane/16-bit serializer
module tb_rj_tx_lane_serializer;
    typedef struct {
        bit          wide;
        logic [15:0] data;
        int          cl;
        int          ch;
        int          l;
        int          h;
        int          ml;
        int          mh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_clk_h, cfg_clk_l;
    logic        cfg_free_run;
    logic        vld_n, vld_w, rdy_n, rdy_w;
    logic [7:0]  dat_n;
    logic [15:0] dat_w;
    logic [1:0]  lane_n;
    logic [4:0]  lane_w;
    logic        busy_n, busy_w, done_n, done_w;
    int          errors = 0;
    int          checks = 0;

    rj_tx_lane_serializer #(.NUM_LANES(1), .DATA_W(8), .CNT_W(8)) dut_n (
        .clk(clk), .rst(rst), .cfg_clk_h(cfg_clk_h), .cfg_clk_l(cfg_clk_l),
        .cfg_free_run(cfg_free_run), .in_valid(vld_n), .in_data(dat_n), .in_ready(rdy_n),
        .rj_lane(lane_n), .busy(busy_n), .tx_done(done_n)
    );

    rj_tx_lane_serializer #(.NUM_LANES(4), .DATA_W(16), .CNT_W(8)) dut_w (
        .clk(clk), .rst(rst), .cfg_clk_h(cfg_clk_h), .cfg_clk_l(cfg_clk_l),
        .cfg_free_run(cfg_free_run), .in_valid(vld_w), .in_data(dat_w), .in_ready(rdy_w),
        .rj_lane(lane_w), .busy(busy_w), .tx_done(done_w)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int lane_dat(input bit w);
        return w ? int'(lane_w[3:0]) : int'(lane_n[0]);
    endfunction
    function automatic int lane_clk(input bit w);
        return w ? int'(lane_w[4]) : int'(lane_n[1]);
    endfunction
    function automatic int rdy_of(input bit w);
        return w ? int'(rdy_w) : int'(rdy_n);
    endfunction
    function automatic int busy_of(input bit w);
        return w ? int'(busy_w) : int'(busy_n);
    endfunction
    function automatic int done_of(input bit w);
        return w ? int'(done_w) : int'(done_n);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic wait_ready(input bit w);
        int n;
        n = 0;
        #1;
        while (rdy_of(w) == 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_wait", rdy_of(w), 1);
    endtask

    // Called just before the accepting posedge; checks every cycle of the word plus the tx_done cycle
    task automatic check_word(input vec_t v);
        int w, p, k;
        w = (v.wide ? 4 : 8) * (v.l + v.h);
        for (int t = 1; t <= w + 1; t++) begin
            @(negedge clk);
            if (t == 1) begin
                vld_n = 1'b0;
                vld_w = 1'b0;
            end
            if (t <= w) begin
                p = (t - 1) % (v.l + v.h);
                k = (t - 1) / (v.l + v.h);
                chk("lane_data", lane_dat(v.wide),
                    v.wide ? int'((v.data >> (4 * k)) & 16'hF) : int'((v.data >> k) & 16'h1));
                chk("lane_clk", lane_clk(v.wide), int'(p >= v.l));
                chk("busy", busy_of(v.wide), 1);
                chk("tx_done_early", done_of(v.wide), 0);
                chk("in_ready", rdy_of(v.wide), int'(t == w));
                if (t == 2 && v.ml >= 0) begin
                    cfg_clk_l = 8'(v.ml);
                    cfg_clk_h = 8'(v.mh);
                end
            end else begin
                chk("tx_done", done_of(v.wide), 1);
                chk("busy_end", busy_of(v.wide), 0);
                chk("lane_data_idle", lane_dat(v.wide), 0);
                chk("lane_clk_idle", lane_clk(v.wide), 0);
            end
        end
    endtask

    task automatic run_word(input vec_t v);
        cfg_clk_l = 8'(v.cl);
        cfg_clk_h = 8'(v.ch);
        if (v.wide) begin
            vld_w = 1'b1;
            dat_w = v.data;
        end else begin
            vld_n = 1'b1;
            dat_n = v.data[7:0];
        end
        wait_ready(v.wide);
        check_word(v);
    endtask

    initial begin
        vec_t vecs [7];
        vec_t fv;
        int   n;
        vecs[0] = '{1'b0, 16'h00A5, 2, 2, 2, 2, -1, -1};
        vecs[1] = '{1'b1, 16'h1234, 1, 3, 1, 3, -1, -1};
        vecs[2] = '{1'b0, 16'h003C, 0, 0, 1, 1, -1, -1};
        vecs[3] = '{1'b0, 16'h0096, 1, 1, 1, 1, 3, 2};
        vecs[4] = '{1'b0, 16'h005A, 3, 2, 3, 2, -1, -1};
        vecs[5] = '{1'b1, 16'hABCD, 2, 1, 2, 1, 0, 5};
        vecs[6] = '{1'b1, 16'h0F0F, 0, 5, 1, 5, -1, -1};

        rst = 1'b1;
        cfg_clk_h = 8'd1;
        cfg_clk_l = 8'd1;
        cfg_free_run = 1'b0;
        vld_n = 1'b0;
        vld_w = 1'b0;
        dat_n = '0;
        dat_w = '0;
        repeat (2) @(negedge clk);
        chk("rst_lane_n", int'(lane_n), 0);
        chk("rst_lane_w", int'(lane_w), 0);
        chk("rst_busy", busy_of(0), 0);
        chk("rst_done", done_of(0), 0);
        chk("rst_ready_n", rdy_of(0), 0);
        chk("rst_ready_w", rdy_of(1), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_n", rdy_of(0), 1);
        chk("post_rst_ready_w", rdy_of(1), 1);

        for (int i = 0; i < 7; i++) run_word(vecs[i]);

        cfg_clk_l = 8'd1;
        cfg_clk_h = 8'd1;
        vld_n = 1'b1;
        dat_n = 8'hFF;
        wait_ready(0);
        for (int t = 1; t <= 33; t++) begin
            @(negedge clk);
            chk("b2b_clk", lane_clk(0), int'(t <= 32 && t % 2 == 0));
            chk("b2b_data", lane_dat(0), int'(t <= 16));
            chk("b2b_done", done_of(0), int'(t == 17 || t == 33));
            chk("b2b_busy", busy_of(0), int'(t <= 32));
            if (t <= 32) chk("b2b_ready", rdy_of(0), int'(t == 16 || t == 32));
            if (t == 1) dat_n = 8'h00;
            if (t == 17) vld_n = 1'b0;
        end

        cfg_clk_l = 8'd3;
        cfg_clk_h = 8'd1;
        cfg_free_run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lane_clk(0) == 0 && n < 50);
        chk("fr_rise", lane_clk(0), 1);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) @(negedge clk);
            chk("fr_clk", lane_clk(0), int'(i % 4 == 0));
            chk("fr_ready", rdy_of(0), int'(i % 4 == 0));
            chk("fr_data", lane_dat(0), 0);
            chk("fr_busy", busy_of(0), 0);
            if (i == 5) begin
                vld_n = 1'b1;
                dat_n = 8'h81;
            end
        end
        fv = '{1'b0, 16'h0081, 3, 1, 3, 1, -1, -1};
        check_word(fv);
        cfg_free_run = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("park_clk", lane_clk(0), 0);
            chk("park_ready", rdy_of(0), int'(j == 3));
        end

        cfg_clk_l = 8'd2;
        cfg_clk_h = 8'd2;
        vld_n = 1'b1;
        dat_n = 8'hFF;
        wait_ready(0);
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            if (t == 1) vld_n = 1'b0;
        end
        chk("mid_busy", busy_of(0), 1);
        chk("mid_data", lane_dat(0), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_lane_n", int'(lane_n), 0);
        chk("abort_busy", busy_of(0), 0);
        chk("abort_ready", rdy_of(0), 0);
        chk("abort_done", done_of(0), 0);
        chk("abort_lane_w", int'(lane_w), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_release_ready", rdy_of(0), 1);
        chk("abort_release_lane", int'(lane_n), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
